// File: rtl/saph_float_capture_fifo.sv
// saph_float_capture_fifo
//   Samples the incrementer's cur vector on each rising edge of its ready
//   output while armed for a programmed number of samples. Captured vectors
//   are buffered in a small first-word-fall-through FIFO and drained over a
//   valid/ack handshake.
//
//   Handshake: out_valid is high whenever the FIFO holds an entry; the head
//   is popped on a clock edge where out_valid and out_ack are both high.
//   out_ack while empty does nothing. out_data/out_stamp are zero when empty.
//
//   Optional build macro SAPH_CAPTURE_TIMESTAMP_EN adds a free-running cycle
//   counter, a per-entry stamp store and the out_stamp output.
module saph_float_capture_fifo #(
  parameter int LANES = 2,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      arm,
  input  logic [7:0]                arm_count,
  input  logic                      in_ready,
  input  logic [LANES*32-1:0]       in_data,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow,
  output logic                      out_valid,
  input  logic                      out_ack,
  output logic [LANES*32-1:0]       out_data,
`ifdef SAPH_CAPTURE_TIMESTAMP_EN
  output logic [31:0]               out_stamp,
`endif
  output logic [$clog2(DEPTH):0]    level
);

  localparam int W  = LANES * 32;
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Pointer MSB separates full from empty; pointers wrap modulo 2*DEPTH.
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]    remaining_q, remaining_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          overflow_q, overflow_d;
  logic          ready_q, ready_d;

  logic [W-1:0]  mem_q [DEPTH];

  logic          full, empty;
  logic          cap_event, capture, push, pop, drop;
  logic [PW-1:0] ptr_xor;

  // Occupancy flags, handshake decode and capture decisions.
  always_comb begin
    ptr_xor   = wr_ptr_q ^ rd_ptr_q;
    full      = (ptr_xor == PW'(DEPTH));
    empty     = (wr_ptr_q == rd_ptr_q);
    cap_event = in_ready & ~ready_q;
    // An event coincident with arm is ignored; counting starts next cycle.
    capture   = cap_event & busy_q & ~arm;
    pop       = out_ack & ~empty;
    // A full FIFO still accepts a sample when the head leaves this cycle.
    push      = capture & (~full | pop);
    drop      = capture & ~push;
  end

  // Next-state for pointers, sample counter and status flags.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    remaining_d = remaining_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    overflow_d  = overflow_q;
    ready_d     = in_ready;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    if (arm) begin
      remaining_d = arm_count;
      busy_d      = (arm_count != 8'd0);
      overflow_d  = 1'b0;
    end else if (capture) begin
      remaining_d = remaining_q - 8'd1;
      if (drop) overflow_d = 1'b1;
      if (remaining_q == 8'd1) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      remaining_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      remaining_q <= remaining_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
      ready_q     <= ready_d;
    end
  end

  // FIFO storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_data;
  end

`ifdef SAPH_CAPTURE_TIMESTAMP_EN
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] stamp_q [DEPTH];

  // Free-running cycle counter.
  always_comb begin
    cycle_d = cycle_q + 32'd1;
  end

  // Cycle counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cycle_q <= '0;
    else      cycle_q <= cycle_d;
  end

  // Stamp store written alongside the data entry.
  always_ff @(posedge clk) begin
    if (push) stamp_q[wr_ptr_q[AW-1:0]] <= cycle_q;
  end

  // Head stamp, zero when empty.
  always_comb begin
    out_stamp = empty ? 32'd0 : stamp_q[rd_ptr_q[AW-1:0]];
  end
`endif

  // Output drive: fall-through head, occupancy and status.
  always_comb begin
    out_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    out_valid = ~empty;
    level     = wr_ptr_q - rd_ptr_q;
    busy      = busy_q;
    done      = done_q;
    overflow  = overflow_q;
  end

endmodule

// File: tb/tb_saph_float_capture_fifo.sv
module tb_saph_float_capture_fifo;

  logic        clk;
  logic        rst;
  logic        arm;
  logic [7:0]  arm_count;
  logic        in_ready;
  logic [63:0] in_data;
  logic        busy, done, overflow, out_valid;
  logic        out_ack;
  logic [63:0] out_data;
  logic [2:0]  level;
`ifdef SAPH_CAPTURE_TIMESTAMP_EN
  logic [31:0] out_stamp;
`endif

  int checks = 0;
  int errors = 0;

  saph_float_capture_fifo #(.LANES(2), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .arm       (arm),
    .arm_count (arm_count),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow),
    .out_valid (out_valid),
    .out_ack   (out_ack),
    .out_data  (out_data),
`ifdef SAPH_CAPTURE_TIMESTAMP_EN
    .out_stamp (out_stamp),
`endif
    .level     (level)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        arm;
    logic [7:0]  cnt;
    logic        rdy;
    logic [63:0] din;
    logic        ack;
    logic        e_busy;
    logic        e_done;
    logic        e_ov;
    logic        e_valid;
    logic [2:0]  e_level;
    logic [63:0] e_data;
  } vec_t;

  vec_t vecs[$];

  // Distinct float-like sample pattern per index: lane1 | lane0.
  function automatic logic [63:0] smp(input int k);
    return {32'h40490000 + 32'(k), 32'h3F800000 + 32'(k)};
  endfunction

  function automatic vec_t mk(input logic a, input logic [7:0] c, input logic r,
                              input logic [63:0] d, input logic k,
                              input logic eb, input logic ed, input logic eo,
                              input logic ev, input logic [2:0] el,
                              input logic [63:0] edat);
    vec_t v;
    v.arm = a; v.cnt = c; v.rdy = r; v.din = d; v.ack = k;
    v.e_busy = eb; v.e_done = ed; v.e_ov = eo; v.e_valid = ev;
    v.e_level = el; v.e_data = edat;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Driver: apply inputs, advance one edge, settle past it.
  task automatic cyc(input logic a, input logic [7:0] c, input logic r,
                     input logic [63:0] d, input logic k);
    arm = a; arm_count = c; in_ready = r; in_data = d; out_ack = k;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string nm, input logic eb, input logic ed,
                         input logic eo, input logic ev, input logic [2:0] el,
                         input logic [63:0] edat);
    chk({nm, "_busy"},  64'(busy),      64'(eb));
    chk({nm, "_done"},  64'(done),      64'(ed));
    chk({nm, "_ovf"},   64'(overflow),  64'(eo));
    chk({nm, "_valid"}, 64'(out_valid), 64'(ev));
    chk({nm, "_level"}, 64'(level),     64'(el));
    chk({nm, "_data"},  out_data,       edat);
  endtask

  initial begin
    // Captures with continuous ack: each sample appears then leaves.
    vecs.push_back(mk(1, 3, 0, 0,      1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, smp(1), 1, 1, 0, 0, 1, 1, smp(1)));
    vecs.push_back(mk(0, 0, 0, 0,      1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, smp(2), 1, 1, 0, 0, 1, 1, smp(2)));
    vecs.push_back(mk(0, 0, 0, 0,      1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, smp(3), 1, 0, 1, 0, 1, 1, smp(3)));
    vecs.push_back(mk(0, 0, 0, 0,      1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, smp(4), 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,      0, 0, 0, 0, 0, 0, 0));
    // Overflow: arm 6, no ack, six events.
    vecs.push_back(mk(1, 6, 0, 0,       0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, smp(11), 0, 1, 0, 0, 1, 1, smp(11)));
    vecs.push_back(mk(0, 0, 0, 0,       0, 1, 0, 0, 1, 1, smp(11)));
    vecs.push_back(mk(0, 0, 1, smp(12), 0, 1, 0, 0, 1, 2, smp(11)));
    vecs.push_back(mk(0, 0, 0, 0,       0, 1, 0, 0, 1, 2, smp(11)));
    vecs.push_back(mk(0, 0, 1, smp(13), 0, 1, 0, 0, 1, 3, smp(11)));
    vecs.push_back(mk(0, 0, 0, 0,       0, 1, 0, 0, 1, 3, smp(11)));
    vecs.push_back(mk(0, 0, 1, smp(14), 0, 1, 0, 0, 1, 4, smp(11)));
    vecs.push_back(mk(0, 0, 0, 0,       0, 1, 0, 0, 1, 4, smp(11)));
    vecs.push_back(mk(0, 0, 1, smp(15), 0, 1, 0, 1, 1, 4, smp(11)));
    vecs.push_back(mk(0, 0, 0, 0,       0, 1, 0, 1, 1, 4, smp(11)));
    vecs.push_back(mk(0, 0, 1, smp(16), 0, 0, 1, 1, 1, 4, smp(11)));
    vecs.push_back(mk(0, 0, 0, 0,       0, 0, 0, 1, 1, 4, smp(11)));
    vecs.push_back(mk(0, 0, 0, 0,       1, 0, 0, 1, 1, 3, smp(12)));
    vecs.push_back(mk(0, 0, 0, 0,       1, 0, 0, 1, 1, 2, smp(13)));
    vecs.push_back(mk(0, 0, 0, 0,       1, 0, 0, 1, 1, 1, smp(14)));
    vecs.push_back(mk(0, 0, 0, 0,       1, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,       1, 0, 0, 1, 0, 0, 0));
    // arm with count 0: clears overflow, no capture, no done.
    vecs.push_back(mk(1, 0, 0, 0,       0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, smp(5),  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,       0, 0, 0, 0, 0, 0, 0));
    // arm coincident with an event: event ignored.
    vecs.push_back(mk(1, 1, 1, smp(6),  0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,       0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, smp(7),  0, 0, 1, 0, 1, 1, smp(7)));
    vecs.push_back(mk(0, 0, 0, 0,       1, 0, 0, 0, 0, 0, 0));

    // Reset state, checked while reset is held.
    rst = 1'b0; arm = 0; arm_count = 0; in_ready = 0; in_data = 0; out_ack = 0;
    #1;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
`ifdef SAPH_CAPTURE_TIMESTAMP_EN
    chk("reset_stamp", 64'(out_stamp), 64'd0);
`endif
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].arm, vecs[i].cnt, vecs[i].rdy, vecs[i].din, vecs[i].ack);
      chk_all($sformatf("v%0d", i), vecs[i].e_busy, vecs[i].e_done, vecs[i].e_ov,
              vecs[i].e_valid, vecs[i].e_level, vecs[i].e_data);
    end

    // Full FIFO: event and pop in the same cycle is accepted.
    cyc(1, 5, 0, 0, 0);
    for (int k = 21; k <= 24; k++) begin
      cyc(0, 0, 1, smp(k), 0);
      cyc(0, 0, 0, 0, 0);
    end
    chk_all("full_pre", 1, 0, 0, 1, 4, smp(21));
    cyc(0, 0, 1, smp(25), 1);
    chk_all("full_pushpop", 0, 1, 0, 1, 4, smp(22));
    for (int k = 23; k <= 25; k++) begin
      cyc(0, 0, 0, 0, 1);
      chk_all($sformatf("full_drain%0d", k), 0, 0, 0, 1, 3'(25 - k + 1), smp(k));
    end
    cyc(0, 0, 0, 0, 1);
    chk_all("full_empty", 0, 0, 0, 0, 0, 0);

    // Level held high counts once.
    cyc(1, 2, 0, 0, 0);
    for (int c = 0; c < 5; c++) cyc(0, 0, 1, smp(31), 0);
    chk_all("held", 1, 0, 0, 1, 1, smp(31));
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, smp(32), 0);
    chk_all("held_second", 0, 1, 0, 1, 2, smp(31));
    cyc(0, 0, 0, 0, 1);
    chk_all("held_pop1", 0, 0, 0, 1, 1, smp(32));
    cyc(0, 0, 0, 0, 1);
    chk_all("held_pop2", 0, 0, 0, 0, 0, 0);

    // Mid-operation asynchronous reset.
    cyc(1, 5, 0, 0, 0);
    for (int k = 41; k <= 43; k++) begin
      cyc(0, 0, 1, smp(k), 0);
      cyc(0, 0, 0, 0, 0);
    end
    chk_all("mid_pre", 1, 0, 0, 1, 3, smp(41));
    #2 rst = 1'b0;
    #1;
    chk_all("mid_reset", 0, 0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cyc(0, 0, 1, smp(50 + c), 0);
      cyc(0, 0, 0, 0, 0);
    end
    chk_all("post_reset_idle", 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(0, 0, 1, smp(60), 0);
    chk_all("post_reset_cap", 0, 1, 0, 1, 1, smp(60));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/saph_float_capture_fifo.md
Name: saph_float_capture_fifo

Overview:
- Downstream consumer of saph_float_incrementer.
- Samples the incrementer's `cur` vector on each rising edge of its `ready` output, while armed for a programmed number of samples.
- Buffers captured vectors in a small FIFO and presents them to a consumer over a valid/ack handshake.
- Used to drain FPU-produced float sequences into testbench monitors or later pipeline stages without stalling the incrementer.

Parameters:
- lanes, 2, number of float lanes per sample; matches the incrementer's lane count.
- depth, 4, FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  GPU clock.
- rst  input  1  asynchronous, active-low reset.
- arm  input  1  one-cycle pulse: load arm_count, clear overflow, start capturing.
- arm_count  input  8  number of samples to capture after arm.
- in_ready  input  1  incrementer ready output.
- in_data  input  float[lanes]  incrementer cur output.
- busy  output  1  high while captures remain.
- done  output  1  one-cycle pulse when the last requested sample is captured or dropped.
- overflow  output  1  sticky: a sample was dropped because the FIFO was full.
- out_valid  output  1  FIFO non-empty.
- out_ack  input  1  consumer pops the head when out_valid and out_ack are both high.
- out_data  output  float[lanes]  head entry; all-zero when empty.
- level  output  $clog2(depth)+1  current occupancy, 0..depth.

Behaviour:
- Reset, rst low, asynchronous: read/write pointers 0, level 0, out_valid 0, out_data 0, busy 0, done 0, overflow 0, remaining counter 0, edge-detect register 0. FIFO storage is not reset.
- Edge detect:
  - in_ready is registered each cycle.
  - A capture event is in_ready high while the registered copy is low.
  - A level held high counts once.
- Arm:
  - On arm: remaining <= arm_count; busy <= (arm_count != 0); overflow <= 0.
  - arm with arm_count 0: no capture and no done pulse.
  - arm while busy restarts the count; FIFO contents are kept.
  - arm and a capture event in the same cycle: the event is ignored; counting starts next cycle.
- Capture, on an event while busy:
  - Push in_data if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise drop the sample and set overflow.
  - In both cases remaining decrements.
  - When remaining goes 1 -> 0: busy <= 0 and done pulses high for exactly one cycle.
- Events while not busy are ignored.
- Pointers:
  - Width $clog2(depth)+1; the MSB distinguishes full from empty.
  - Wrap modulo 2*depth.
  - full = (wr ^ rd) == {1'b1, zeros}; empty = (wr == rd).
- Output:
  - out_data is combinational from storage[rd] when non-empty, zero when empty. Zero-latency first-word fall-through: data pushed in cycle N is visible in cycle N+1.
  - Pop when empty has no effect.
  - Push and pop in the same cycle leave level unchanged.
- level updates on the cycle after each push or pop; it is never greater than depth.

Optional Feature:
- SAPH_CAPTURE_TIMESTAMP_EN defined:
  - Adds output out_stamp, 32 bits.
  - A free-running cycle counter resets to 0 and increments every clk.
  - Each FIFO entry stores the counter value at capture; out_stamp shows the head entry's value, zero when empty.
- Not defined: no counter, no stamp storage, no out_stamp port.

Test Plan:
- Incrementer running with init {1.010, 3.141} and inc {0.125, 0.001}; arm with arm_count 3, consumer acks continuously.
  - Expect out_data {1.135, 3.142}, then {1.260, 3.143}, then {1.385, 3.144}.
  - done pulses once; busy falls with done; overflow stays 0.
- depth 4, out_ack held 0, arm_count 6, six capture events.
  - level saturates at 4; overflow = 1 after the fifth event.
  - done pulses after the sixth event; the first four samples pop in order afterwards.
- FIFO full, capture event and out_ack in the same cycle: push accepted, level stays 4, overflow stays 0.
- in_ready held high for 5 cycles with arm_count 2: exactly one sample captured, busy stays 1; a second rising edge captures it and done pulses.
- Mid-operation reset: rst low with level 3 and busy 1.
  - All outputs go 0 immediately, without waiting for clk.
  - After release, out_valid stays 0 until the next arm and capture.
- With SAPH_CAPTURE_TIMESTAMP_EN: events at cycles 10 and 17 after reset release give out_stamp 10 then 17.
